controlador_estados: RTL and testbench
======================================

// Module: controlador_estados
// PURPOSE
//  Top-level pet FSM. It produces the one-hot `estado` bus that drives the attribute
//  controller (fome/felicidade/sono) and the display logic.
//  Inputs are raw push-buttons and the three attribute levels. The block starts, cancels
//  and times activities (sleep, eat, teach), detects death and issues a one-cycle restart.
//  It generates the game tick from a free-running prescaler.
// PARAMETERS
//  TICK_DIV     65536  clk cycles per game tick (matches attribute update period)
//  DURACAO      8'd20  activity length in ticks
//  MORTE_TICKS  8'd10  consecutive ticks with any attribute == 0 before death
//  MAX_ATRIB    8'd100 attribute ceiling; an activity ends/rejects at >= this
// PORTS
//  clk             in   1  system clock, rising edge
//  rst_n           in   1  asynchronous active-low reset
//  btn_inicio      in   1  raw start/cancel/restart button, active-high, async
//  btn_comer       in   1  raw "eat" button, active-high, async
//  btn_dormir      in   1  raw "sleep" button, active-high, async
//  btn_aula        in   1  raw "teach" button, active-high, async
//  fome            in   8  hunger level 0..100
//  felicidade      in   8  happiness level 0..100
//  sono            in   8  rest level 0..100
//  estado          out  5  INTRO=00000 IDLE=00001 DORMINDO=00010 COMENDO=00100 DANDO_AULA=01000 MORTO=10000
//  tick            out  1  one-cycle game tick pulse
//  tempo_restante  out  8  ticks left in current activity, 0 outside activities
//  reiniciar       out  1  one-cycle pulse: attribute block reloads initial values
// BEHAVIOUR
//  Reset (async, immediate): estado=INTRO, tick=0, tempo_restante=0, reiniciar=0,
//   prescaler=0, zero-counter=0, button sync/edge flops=0.
//  Buttons: 2-flop sync + rising-edge detect -> pulse exactly 1 cycle wide.
//   Pulse appears 3 clk edges after the raw rise; holding a button gives one pulse only.
//  Prescaler: counts 0..TICK_DIV-1 in every state; tick=1 in the cycle the count is TICK_DIV-1.
//  Death monitor (IDLE and activity states only): on each tick, if any attribute == 0,
//   zcnt++, otherwise zcnt=0. zcnt==MORTE_TICKS -> MORTO on the next edge.
//   Death has priority over every other transition. zcnt clears on entry to INTRO.
//  FSM transitions (registered, one cycle after the qualifying event):
//   INTRO: inicio pulse -> IDLE. Other buttons are ignored.
//   IDLE: priority dormir > comer > aula when pulses coincide.
//    Request is accepted only if its target (sono/fome/felicidade) < MAX_ATRIB.
//    A rejected request leaves estado=IDLE; lower-priority pulses in the same cycle are dropped.
//    Accept -> activity state, tempo_restante=DURACAO.
//   Activity: on each tick, tempo_restante-- (saturates at 0). The activity returns to IDLE,
//    with tempo_restante=0, when any of these holds:
//    (a) tick arrives with tempo_restante==1
//    (b) target attribute >= MAX_ATRIB
//    (c) inicio pulse (cancel)
//    Other activity buttons are ignored. Exit and tick in the same cycle: exit wins, count ends at 0.
//   MORTO: inicio pulse -> INTRO with reiniciar=1 for that single cycle. Other buttons are ignored.
//  Reset mid-activity: abandons the activity with no reiniciar pulse.
//  Illegal estado encoding: forced to INTRO on the next edge.
// STRUCTURE
//  Shared package pkg_tamagotchi: state localparams, MAX_ATRIB, attribute width (8).
//   controlador_atributos imports the same encodings.
//  Sub-module detector_borda: sync + edge detect, instantiated once per button (4x).
//  Remaining logic (prescaler, zcnt, FSM, activity timer) lives in this module.
// TESTING (TICK_DIV=4, DURACAO=3, MORTE_TICKS=2)
//  1. rst_n low mid-count, then release -> estado=00001?no: estado=00000, tick=0, tempo_restante=0;
//     inicio held 10 cycles -> exactly one transition to IDLE.
//  2. IDLE, dormir+comer same cycle, sono=50 -> DORMINDO, tempo_restante=3.
//     After 3 ticks -> IDLE, tempo_restante=0.
//  3. IDLE, comer with fome=100 -> stays IDLE.
//     Then comer with fome=60 -> COMENDO; drive fome=100 -> IDLE next edge.
//  4. DANDO_AULA, inicio pulse -> IDLE; aula pulse during activity -> no effect.
//  5. IDLE, sono=0 for 2 ticks -> MORTO; sono=0 for 1 tick, then 5 -> stays IDLE.
//  6. MORTO, inicio pulse -> INTRO with reiniciar high exactly 1 cycle; comer in MORTO -> ignored.

Source files
------------

// File: rtl/pkg_tamagotchi.sv
// Shared encodings for the pet controllers: one-hot activity states, attribute
// width and ceiling, plus a small helper used by the death monitor.
package pkg_tamagotchi;

  localparam int ATRIB_W = 8;
  localparam logic [ATRIB_W-1:0] MAX_ATRIB = 8'd100;

  typedef enum logic [4:0] {
    INTRO      = 5'b00000,
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } estado_t;

  function automatic logic algum_zero(input logic [ATRIB_W-1:0] a,
                                      input logic [ATRIB_W-1:0] b,
                                      input logic [ATRIB_W-1:0] c);
    return (a == 8'd0) || (b == 8'd0) || (c == 8'd0);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Push-button front end: two-flop synchroniser followed by a registered
// rising-edge detector, so a press of any length yields one single-cycle pulse.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulso_o
);

  logic sinc1_q;
  logic sinc2_q;
  logic ant_q;
  logic pulso_q;

  // synchroniser chain and edge-pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
      ant_q   <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      sinc1_q <= btn_i;
      sinc2_q <= sinc1_q;
      ant_q   <= sinc2_q;
      pulso_q <= sinc2_q & ~ant_q;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/controlador_estados.sv
// Pet top-level FSM: game tick prescaler, death monitor, activity timer and the
// one-hot estado bus consumed by the attribute controller and display.
module controlador_estados
  import pkg_tamagotchi::*;
#(
  parameter int unsigned TICK_DIV    = 65536,
  parameter logic [7:0]  DURACAO     = 8'd20,
  parameter logic [7:0]  MORTE_TICKS = 8'd10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_inicio,
  input  logic                btn_comer,
  input  logic                btn_dormir,
  input  logic                btn_aula,
  input  logic [ATRIB_W-1:0]  fome,
  input  logic [ATRIB_W-1:0]  felicidade,
  input  logic [ATRIB_W-1:0]  sono,
  output logic [4:0]          estado,
  output logic                tick,
  output logic [7:0]          tempo_restante,
  output logic                reiniciar
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic          inicio_s, comer_s, dormir_s, aula_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;
  estado_t       state_q, state_d;
  logic [7:0]    tempo_q, tempo_d;
  logic [7:0]    zcnt_q, zcnt_d;
  logic          reiniciar_q, reiniciar_d;
  logic [7:0]    alvo_s;
  logic          vivo_s;

  detector_borda u_det_inicio (.clk(clk), .rst_n(rst_n), .btn_i(btn_inicio), .pulso_o(inicio_s));
  detector_borda u_det_comer  (.clk(clk), .rst_n(rst_n), .btn_i(btn_comer),  .pulso_o(comer_s));
  detector_borda u_det_dormir (.clk(clk), .rst_n(rst_n), .btn_i(btn_dormir), .pulso_o(dormir_s));
  detector_borda u_det_aula   (.clk(clk), .rst_n(rst_n), .btn_i(btn_aula),   .pulso_o(aula_s));

  // free-running prescaler; tick is registered so it is high while the count sits at CNT_MAX
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // attribute that the current activity is trying to fill
  always_comb begin
    vivo_s = (state_q == IDLE) || (state_q == DORMINDO) ||
             (state_q == COMENDO) || (state_q == DANDO_AULA);
    case (state_q)
      DORMINDO:   alvo_s = sono;
      COMENDO:    alvo_s = fome;
      DANDO_AULA: alvo_s = felicidade;
      default:    alvo_s = 8'd0;
    endcase
  end

  // next-state, activity timer and death counter
  always_comb begin
    state_d     = state_q;
    tempo_d     = tempo_q;
    zcnt_d      = zcnt_q;
    reiniciar_d = 1'b0;

    if (vivo_s && tick_q) begin
      if (algum_zero(fome, felicidade, sono)) begin
        zcnt_d = (zcnt_q >= MORTE_TICKS) ? MORTE_TICKS : zcnt_q + 8'd1;
      end else begin
        zcnt_d = 8'd0;
      end
    end else begin
      zcnt_d = zcnt_q;
    end

    case (state_q)
      INTRO: begin
        if (inicio_s) begin
          state_d = IDLE;
        end else begin
          state_d = INTRO;
        end
      end
      IDLE: begin
        // a rejected higher-priority request swallows the lower ones
        if (dormir_s) begin
          if (sono < MAX_ATRIB) begin
            state_d = DORMINDO;
            tempo_d = DURACAO;
          end else begin
            state_d = IDLE;
          end
        end else if (comer_s) begin
          if (fome < MAX_ATRIB) begin
            state_d = COMENDO;
            tempo_d = DURACAO;
          end else begin
            state_d = IDLE;
          end
        end else if (aula_s) begin
          if (felicidade < MAX_ATRIB) begin
            state_d = DANDO_AULA;
            tempo_d = DURACAO;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DORMINDO, COMENDO, DANDO_AULA: begin
        if (inicio_s || (alvo_s >= MAX_ATRIB) || (tick_q && (tempo_q == 8'd1))) begin
          state_d = IDLE;
          tempo_d = 8'd0;
        end else if (tick_q && (tempo_q != 8'd0)) begin
          tempo_d = tempo_q - 8'd1;
        end else begin
          tempo_d = tempo_q;
        end
      end
      MORTO: begin
        if (inicio_s) begin
          state_d     = INTRO;
          reiniciar_d = 1'b1;
          zcnt_d      = 8'd0;
        end else begin
          state_d = MORTO;
        end
      end
      default: begin
        state_d = INTRO;
        tempo_d = 8'd0;
        zcnt_d  = 8'd0;
      end
    endcase

    if (vivo_s && (zcnt_q == MORTE_TICKS)) begin
      state_d = MORTO;
      tempo_d = 8'd0;
    end else begin
      state_d = state_d;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= {CW{1'b0}};
      tick_q      <= 1'b0;
      state_q     <= INTRO;
      tempo_q     <= 8'd0;
      zcnt_q      <= 8'd0;
      reiniciar_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tick_q      <= (cnt_d == CNT_MAX);
      state_q     <= state_d;
      tempo_q     <= tempo_d;
      zcnt_q      <= zcnt_d;
      reiniciar_q <= reiniciar_d;
    end
  end

  assign estado         = state_q;
  assign tick           = tick_q;
  assign tempo_restante = tempo_q;
  assign reiniciar      = reiniciar_q;

endmodule

// File: tb/tb_controlador_estados.sv
// Self-checking bench for controlador_estados: a mode-level reference model is
// advanced every edge and compared with the DUT, plus directed literal checks.
module tb_controlador_estados;

  localparam int TD  = 4;
  localparam int DUR = 3;
  localparam int MT  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_v = 4'b0000;   // 0 inicio, 1 comer, 2 dormir, 3 aula
  logic [7:0] fome = 8'd50, felicidade = 8'd50, sono = 8'd50;
  logic [4:0] estado;
  logic       tick;
  logic [7:0] tempo_restante;
  logic       reiniciar;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: mode 0 intro, 1 idle, 2 sleep, 3 eat, 4 teach, 5 dead
  int         m_modo, m_tempo, m_zc, m_k;
  bit         m_rein;
  logic [3:0] hist [4];

  always #5 clk = ~clk;

  controlador_estados #(.TICK_DIV(TD), .DURACAO(8'd3), .MORTE_TICKS(8'd2)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_inicio(btn_v[0]), .btn_comer(btn_v[1]), .btn_dormir(btn_v[2]), .btn_aula(btn_v[3]),
    .fome(fome), .felicidade(felicidade), .sono(sono),
    .estado(estado), .tick(tick), .tempo_restante(tempo_restante), .reiniciar(reiniciar)
  );

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_modo = 0; m_tempo = 0; m_zc = 0; m_k = 0; m_rein = 0;
    for (int b = 0; b < 4; b++) hist[b] = 4'b0000;
  endtask

  task automatic model_edge();
    bit tk, alive, anyz;
    bit p [4];
    int nm, nt, nz, alvo;
    m_k++;
    tk = (((m_k - 1) % TD) == TD - 1);
    for (int b = 0; b < 4; b++) p[b] = hist[b][2] && !hist[b][3];
    alive = (m_modo >= 1) && (m_modo <= 4);
    anyz = (fome == 0) || (felicidade == 0) || (sono == 0);
    nm = m_modo; nt = m_tempo; nz = m_zc; m_rein = 0;
    if (alive && tk) nz = anyz ? ((m_zc < MT) ? m_zc + 1 : MT) : 0;
    if (alive && m_zc == MT) begin
      nm = 5; nt = 0;
    end else if (m_modo == 0) begin
      if (p[0]) nm = 1;
    end else if (m_modo == 1) begin
      if (p[2]) begin
        if (sono < 100) begin nm = 2; nt = DUR; end
      end else if (p[1]) begin
        if (fome < 100) begin nm = 3; nt = DUR; end
      end else if (p[3]) begin
        if (felicidade < 100) begin nm = 4; nt = DUR; end
      end
    end else if (m_modo == 5) begin
      if (p[0]) begin nm = 0; m_rein = 1; nz = 0; end
    end else begin
      alvo = (m_modo == 2) ? int'(sono) : (m_modo == 3) ? int'(fome) : int'(felicidade);
      if (p[0] || alvo >= 100 || (tk && m_tempo == 1)) begin
        nm = 1; nt = 0;
      end else if (tk && m_tempo > 0) begin
        nt = m_tempo - 1;
      end
    end
    m_modo = nm; m_tempo = nt; m_zc = nz;
    for (int b = 0; b < 4; b++) hist[b] = {hist[b][2:0], btn_v[b]};
  endtask

  task automatic compare_all();
    logic [4:0] e;
    e = (m_modo == 0) ? 5'd0 : 5'(1 << (m_modo - 1));
    chk("estado", estado, e);
    chk("tick", tick, ((m_k % TD) == TD - 1) ? 1 : 0);
    chk("tempo_restante", tempo_restante, m_tempo);
    chk("reiniciar", reiniciar, m_rein);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("reset_estado", estado, 5'b00000);
    chk("reset_tick", tick, 0);
    chk("reset_tempo", tempo_restante, 0);
    rst_n = 1'b1;
  endtask

  task automatic press(input int b, input int hold);
    btn_v[b] = 1'b1;
    repeat (hold) cyc();
    btn_v[b] = 1'b0;
  endtask

  task automatic wait_estado(input string nome, input logic [4:0] exp, input int budget, output int n);
    n = 0;
    while (estado !== exp && n < budget) begin
      cyc();
      n++;
    end
    chk(nome, estado, exp);
  endtask

  initial begin
    int n, trans;
    logic [4:0] prev;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // 1: reset mid-count, then a long inicio press gives one transition
    repeat (6) cyc();
    do_reset();
    trans = 0;
    prev = estado;
    btn_v[0] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 10) btn_v[0] = 1'b0;
      cyc();
      if (estado !== prev) trans++;
      prev = estado;
    end
    chk("uma_transicao", trans, 1);
    chk("idle_apos_inicio", estado, 5'b00001);

    // 2: dormir wins over comer; runs exactly three ticks
    btn_v[1] = 1'b1; btn_v[2] = 1'b1;
    repeat (2) cyc();
    btn_v[1] = 1'b0; btn_v[2] = 1'b0;
    wait_estado("entra_dormindo", 5'b00010, 10, n);
    chk("tempo_inicial", tempo_restante, 3);
    wait_estado("fim_dormindo", 5'b00001, 20, n);
    chk("tempo_fim", tempo_restante, 0);
    chk("duracao_atividade", (n >= 9 && n <= 12) ? 1 : 0, 1);

    // 3: full attribute rejects, then early exit on reaching the ceiling
    fome = 8'd100;
    press(1, 1);
    repeat (8) cyc();
    chk("comer_rejeitado", estado, 5'b00001);
    fome = 8'd60;
    press(1, 1);
    wait_estado("entra_comendo", 5'b00100, 10, n);
    fome = 8'd100;
    cyc();
    chk("comer_cheio_sai", estado, 5'b00001);
    fome = 8'd60;

    // 4: aula ignored inside activity; inicio cancels
    press(3, 1);
    wait_estado("entra_aula", 5'b01000, 10, n);
    press(3, 1);
    repeat (4) cyc();
    chk("aula_ignorada", estado, 5'b01000);
    wait_estado("aula_fim", 5'b00001, 20, n);
    press(3, 1);
    wait_estado("entra_aula2", 5'b01000, 10, n);
    press(0, 1);
    wait_estado("aula_cancelada", 5'b00001, 4, n);
    chk("cancel_tempo", tempo_restante, 0);

    // 5: one zero tick is forgiven, two in a row kill
    n = 0;
    while (((m_k % TD) != TD - 1) && n < 10) begin cyc(); n++; end
    sono = 8'd0;
    cyc();
    sono = 8'd5;
    repeat (20) cyc();
    chk("sobrevive_um_tick", estado, 5'b00001);
    sono = 8'd0;
    wait_estado("morre", 5'b10000, 16, n);
    sono = 8'd50;

    // 6: only inicio leaves MORTO, with a single reiniciar pulse
    press(1, 1);
    repeat (6) cyc();
    chk("morto_ignora_comer", estado, 5'b10000);
    press(0, 1);
    wait_estado("volta_intro", 5'b00000, 8, n);
    chk("reiniciar_alto", reiniciar, 1);
    cyc();
    chk("reiniciar_baixo", reiniciar, 0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) btn_v[b] = ~btn_v[b];
      if ($urandom_range(0, 29) == 0) begin
        logic [7:0] v;
        case ($urandom_range(0, 5))
          0: v = 8'd0;
          1: v = 8'd1;
          2: v = 8'd99;
          3: v = 8'd100;
          4: v = 8'd50;
          default: v = 8'($urandom_range(0, 100));
        endcase
        case ($urandom_range(0, 2))
          0: fome = v;
          1: felicidade = v;
          default: sono = v;
        endcase
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
